// File: rtl/iopmp_check_arbiter.sv
// Round-robin sequencer sharing one IOPMP rule-check unit between the AXI AW and AR
// channels; returns a one-cycle registered allow/deny decision to the winning channel.
module iopmp_check_arbiter #(
  parameter int unsigned AddrWidth     = 64,
  parameter int unsigned NsaidWidth    = 4,
  parameter int unsigned TimeoutCycles = 255
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  aw_valid_i,
  input  logic [AddrWidth-1:0]  aw_addr_i,
  input  logic [7:0]            aw_len_i,
  input  logic [2:0]            aw_size_i,
  input  logic [NsaidWidth-1:0] aw_nsaid_i,
  output logic                  aw_done_o,
  output logic                  aw_allow_o,
  input  logic                  ar_valid_i,
  input  logic [AddrWidth-1:0]  ar_addr_i,
  input  logic [7:0]            ar_len_i,
  input  logic [2:0]            ar_size_i,
  input  logic [NsaidWidth-1:0] ar_nsaid_i,
  output logic                  ar_done_o,
  output logic                  ar_allow_o,
  output logic                  chk_valid_o,
  input  logic                  chk_ready_i,
  output logic [AddrWidth-1:0]  chk_addr_o,
  output logic [7:0]            chk_len_o,
  output logic [2:0]            chk_size_o,
  output logic [NsaidWidth-1:0] chk_nsaid_o,
  output logic                  chk_write_o,
  input  logic                  chk_rsp_valid_i,
  input  logic                  chk_allow_i,
  output logic                  timeout_o
);

  localparam int unsigned    CntW    = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'((TimeoutCycles > 0) ? TimeoutCycles - 1 : 0);
  localparam logic [CntW-1:0] CntMax  = '1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  state_e                r_state;
  logic                  r_prio;
  logic [CntW-1:0]       r_cnt;
  logic                  r_chk_valid;
  logic [AddrWidth-1:0]  r_chk_addr;
  logic [7:0]            r_chk_len;
  logic [2:0]            r_chk_size;
  logic [NsaidWidth-1:0] r_chk_nsaid;
  logic                  r_chk_write;
  logic                  r_aw_done, r_aw_allow, r_ar_done, r_ar_allow;

  logic w_grant, w_grant_write, w_timeout, w_verdict;

  assign w_grant       = aw_valid_i | ar_valid_i;
  // AW wins when it is alone or when it holds priority over a simultaneous AR.
  assign w_grant_write = aw_valid_i & (~ar_valid_i | ~r_prio);
  // A verdict in the expiry cycle takes precedence, so it suppresses the timeout.
  assign w_timeout     = (TimeoutCycles != 0) && (r_state == WAIT) && !chk_rsp_valid_i
                         && (r_cnt == CntLast);
  assign w_verdict     = chk_rsp_valid_i & chk_allow_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= IDLE;
      r_prio      <= 1'b0;
      r_cnt       <= '0;
      r_chk_valid <= 1'b0;
      r_chk_addr  <= '0;
      r_chk_len   <= '0;
      r_chk_size  <= '0;
      r_chk_nsaid <= '0;
      r_chk_write <= 1'b0;
      r_aw_done   <= 1'b0;
      r_aw_allow  <= 1'b0;
      r_ar_done   <= 1'b0;
      r_ar_allow  <= 1'b0;
    end else begin
      // NOTE: these non-blocking defaults make every decision a one-cycle pulse; a later
      // <= in the same cycle overrides them because the last scheduled update wins.
      r_aw_done  <= 1'b0;
      r_aw_allow <= 1'b0;
      r_ar_done  <= 1'b0;
      r_ar_allow <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_grant) begin
            r_chk_valid <= 1'b1;
            r_chk_write <= w_grant_write;
            r_chk_addr  <= w_grant_write ? aw_addr_i  : ar_addr_i;
            r_chk_len   <= w_grant_write ? aw_len_i   : ar_len_i;
            r_chk_size  <= w_grant_write ? aw_size_i  : ar_size_i;
            r_chk_nsaid <= w_grant_write ? aw_nsaid_i : ar_nsaid_i;
            r_state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (chk_ready_i) begin
            r_chk_valid <= 1'b0;
            r_cnt       <= '0;
            r_state     <= WAIT;
          end
        end
        WAIT: begin
          if (r_cnt != CntMax) r_cnt <= r_cnt + 1'b1;
          if (chk_rsp_valid_i || w_timeout) begin
            r_aw_done  <= r_chk_write;
            r_ar_done  <= ~r_chk_write;
            r_aw_allow <= r_chk_write & w_verdict;
            r_ar_allow <= ~r_chk_write & w_verdict;
            r_state    <= RESP;
          end
        end
        RESP: begin
          r_prio  <= r_chk_write;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign chk_valid_o = r_chk_valid;
  assign chk_addr_o  = r_chk_addr;
  assign chk_len_o   = r_chk_len;
  assign chk_size_o  = r_chk_size;
  assign chk_nsaid_o = r_chk_nsaid;
  assign chk_write_o = r_chk_write;
  assign aw_done_o   = r_aw_done;
  assign aw_allow_o  = r_aw_allow;
  assign ar_done_o   = r_ar_done;
  assign ar_allow_o  = r_ar_allow;
  assign timeout_o   = w_timeout;

endmodule

// File: tb/tb_iopmp_check_arbiter.sv
// Directed bench for iopmp_check_arbiter: expected {write, allow} decisions are queued
// when a verdict or timeout is provoked and popped by a monitor when a done pulse appears.
module tb_iopmp_check_arbiter;

  logic        clk, rst;
  logic        aw_valid, ar_valid;
  logic [63:0] aw_addr, ar_addr;
  logic [7:0]  aw_len, ar_len;
  logic [2:0]  aw_size, ar_size;
  logic [3:0]  aw_nsaid, ar_nsaid;
  logic        aw_done_o, aw_allow_o, ar_done_o, ar_allow_o;
  logic        chk_valid_o, chk_ready, chk_write_o, chk_rsp_valid, chk_allow, timeout_o;
  logic [63:0] chk_addr_o;
  logic [7:0]  chk_len_o;
  logic [2:0]  chk_size_o;
  logic [3:0]  chk_nsaid_o;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [1:0] sb[$];
  logic       rdy_idle = 1'b0;

  iopmp_check_arbiter #(.AddrWidth(64), .NsaidWidth(4), .TimeoutCycles(4)) dut (
    .clk_i(clk), .rst_i(rst),
    .aw_valid_i(aw_valid), .aw_addr_i(aw_addr), .aw_len_i(aw_len), .aw_size_i(aw_size),
    .aw_nsaid_i(aw_nsaid), .aw_done_o(aw_done_o), .aw_allow_o(aw_allow_o),
    .ar_valid_i(ar_valid), .ar_addr_i(ar_addr), .ar_len_i(ar_len), .ar_size_i(ar_size),
    .ar_nsaid_i(ar_nsaid), .ar_done_o(ar_done_o), .ar_allow_o(ar_allow_o),
    .chk_valid_o(chk_valid_o), .chk_ready_i(chk_ready), .chk_addr_o(chk_addr_o),
    .chk_len_o(chk_len_o), .chk_size_o(chk_size_o), .chk_nsaid_o(chk_nsaid_o),
    .chk_write_o(chk_write_o), .chk_rsp_valid_i(chk_rsp_valid), .chk_allow_i(chk_allow),
    .timeout_o(timeout_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant();
    int n = 0;
    while (!chk_valid_o && n < 20) begin
      step();
      n++;
    end
    check("grant_seen", chk_valid_o, 1);
  endtask

  // Grant -> accept at T1 -> verdict at T2 -> done at T3; returns in T3.
  task automatic do_txn(input logic exp_wr, input logic allow, input logic [63:0] exp_addr,
                        input logic [3:0] exp_nsaid);
    wait_grant();
    check("grant_write", chk_write_o, exp_wr);
    check("grant_addr", chk_addr_o, exp_addr);
    check("grant_nsaid", chk_nsaid_o, exp_nsaid);
    chk_ready = 1'b1;
    step();
    chk_ready = rdy_idle;
    check("accept_drop", chk_valid_o, 0);
    check("early_done", {aw_done_o, ar_done_o}, 0);
    chk_rsp_valid = 1'b1;
    chk_allow     = allow;
    sb.push_back({exp_wr, allow});
    step();
    chk_rsp_valid = 1'b0;
    chk_allow     = 1'b0;
    check("done_pulse", exp_wr ? aw_done_o : ar_done_o, 1);
    check("done_verdict", exp_wr ? aw_allow_o : ar_allow_o, allow);
  endtask

  always @(negedge clk) begin
    if (aw_done_o || ar_done_o) begin
      check("single_done", aw_done_o & ar_done_o, 0);
      if (sb.size() == 0) check("spurious_done", {aw_done_o, ar_done_o}, 0);
      else begin
        logic [1:0] e;
        e = sb.pop_front();
        check("sb_channel", aw_done_o, e[1]);
        check("sb_allow", aw_done_o ? aw_allow_o : ar_allow_o, e[0]);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // NOTE: stimulus uses blocking assignments one time unit after the clock edge, so the
    // DUT always samples settled values and never races the bench.
    rst = 1'b1; aw_valid = 1'b0; ar_valid = 1'b0; chk_ready = 1'b0;
    chk_rsp_valid = 1'b0; chk_allow = 1'b0;
    aw_addr = '0; aw_len = '0; aw_size = '0; aw_nsaid = '0;
    ar_addr = '0; ar_len = '0; ar_size = '0; ar_nsaid = '0;
    repeat (3) step();
    check("rst_chk_valid", chk_valid_o, 0);
    check("rst_chk_fields", {chk_addr_o, chk_len_o, chk_size_o, chk_nsaid_o, chk_write_o}, 0);
    check("rst_decisions", {aw_done_o, aw_allow_o, ar_done_o, ar_allow_o, timeout_o}, 0);

    // Both channels valid from reset with an always-ready checker: AW, AR, AW, AR.
    rst = 1'b0; rdy_idle = 1'b1; chk_ready = 1'b1;
    aw_valid = 1'b1; aw_addr = 64'h0000_0000_1000_0040; aw_nsaid = 4'h1;
    ar_valid = 1'b1; ar_addr = 64'hffff_0000_0000_0800; ar_nsaid = 4'h2;
    for (int k = 0; k < 4; k++)
      do_txn(k % 2 == 0, k % 2 == 0, (k % 2 == 0) ? aw_addr : ar_addr,
             (k % 2 == 0) ? aw_nsaid : ar_nsaid);
    aw_valid = 1'b0; ar_valid = 1'b0; rdy_idle = 1'b0; chk_ready = 1'b0;
    step();

    // Single AR, minimum latency; done only at T3.
    ar_valid = 1'b1; ar_addr = 64'h0000_0000_8000_1000; ar_nsaid = 4'h3;
    do_txn(1'b0, 1'b1, 64'h0000_0000_8000_1000, 4'h3);
    ar_valid = 1'b0;
    step();
    check("ar_done_once", ar_done_o, 0);

    // AW with checker stalling 5 cycles; later input changes must not leak into the check.
    aw_valid = 1'b1; aw_addr = 64'h1234_5678_9abc_def0; aw_len = 8'h3c; aw_size = 3'd2;
    aw_nsaid = 4'ha;
    wait_grant();
    aw_addr = 64'h0; aw_len = 8'h00; aw_nsaid = 4'h5;
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", chk_valid_o, 1);
      check("stall_addr", chk_addr_o, 64'h1234_5678_9abc_def0);
      check("stall_no_timeout", timeout_o, 0);
      step();
    end
    check("stall_valid_6", chk_valid_o, 1);
    check("stall_fields_6", {chk_addr_o, chk_len_o, chk_size_o, chk_nsaid_o, chk_write_o},
          {64'h1234_5678_9abc_def0, 8'h3c, 3'd2, 4'ha, 1'b1});
    chk_ready = 1'b1;
    step();
    chk_ready = 1'b0;
    check("stall_accept", chk_valid_o, 0);
    chk_rsp_valid = 1'b1; chk_allow = 1'b0; sb.push_back(2'b10);
    step();
    chk_rsp_valid = 1'b0;
    check("stall_done", {aw_done_o, aw_allow_o}, 2'b10);
    aw_valid = 1'b0;
    step();

    // Timeout on AR: timeout_o 4 cycles after accept, deny-done the cycle after.
    ar_valid = 1'b1; ar_addr = 64'h0000_0000_0000_4000; ar_nsaid = 4'h7;
    wait_grant();
    chk_ready = 1'b1; sb.push_back(2'b00);
    step();
    chk_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("to_quiet", timeout_o, 0);
      step();
    end
    check("to_pulse", timeout_o, 1);
    check("to_no_done_yet", ar_done_o, 0);
    step();
    check("to_done", {ar_done_o, ar_allow_o, timeout_o}, 3'b100);
    ar_valid = 1'b0;
    step();
    chk_rsp_valid = 1'b1; chk_allow = 1'b1;
    step();
    chk_rsp_valid = 1'b0; chk_allow = 1'b0;
    check("late_verdict_ignored", {aw_done_o, ar_done_o}, 0);
    step();
    check("to_sb_empty", sb.size(), 0);

    // AW verdict in the expiry cycle wins over the timeout.
    aw_valid = 1'b1; aw_addr = 64'h0000_00ab_0000_0000; aw_nsaid = 4'hc;
    wait_grant();
    chk_ready = 1'b1;
    step();
    chk_ready = 1'b0;
    repeat (3) step();
    chk_rsp_valid = 1'b1; chk_allow = 1'b1; sb.push_back(2'b11);
    @(negedge clk);
    check("race_no_timeout", timeout_o, 0);
    step();
    chk_rsp_valid = 1'b0; chk_allow = 1'b0;
    check("race_done", {aw_done_o, aw_allow_o, timeout_o}, 3'b110);
    aw_valid = 1'b0;
    step();

    // Reset during WAIT abandons the check and restores AW priority.
    ar_valid = 1'b1; ar_addr = 64'h0000_0000_0000_9000; ar_nsaid = 4'h9;
    wait_grant();
    chk_ready = 1'b1;
    step();
    chk_ready = 1'b0; rst = 1'b1;
    step();
    check("midrst_chk", {chk_valid_o, chk_addr_o, chk_write_o, chk_nsaid_o}, 0);
    check("midrst_out", {aw_done_o, aw_allow_o, ar_done_o, ar_allow_o, timeout_o}, 0);
    rst = 1'b0; ar_valid = 1'b0; chk_rsp_valid = 1'b1; chk_allow = 1'b1;
    step();
    chk_rsp_valid = 1'b0; chk_allow = 1'b0;
    repeat (6) begin
      check("midrst_quiet", {aw_done_o, ar_done_o, timeout_o, chk_valid_o}, 0);
      step();
    end
    aw_valid = 1'b1; aw_addr = 64'h0000_0000_0000_a000; aw_nsaid = 4'h4;
    ar_valid = 1'b1; ar_addr = 64'h0000_0000_0000_b000; ar_nsaid = 4'h6;
    do_txn(1'b1, 1'b1, 64'h0000_0000_0000_a000, 4'h4);
    aw_valid = 1'b0;
    do_txn(1'b0, 1'b0, 64'h0000_0000_0000_b000, 4'h6);
    ar_valid = 1'b0;
    repeat (3) step();
    check("final_sb_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
